cache_ahb_cfg_regs: RTL and testbench

//  Parametrised AHB-Lite slave holding the cache configuration/status registers.

---
 rtl/cache_cfg_pkg.sv | 41 ++++
 rtl/cache_cfg_sat_cnt.sv | 36 +++
 rtl/cache_ahb_cfg_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_cache_ahb_cfg_regs.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cfg_pkg.sv
// Shared definitions for the cache configuration register slave: register offsets,
// bit positions, FSM state encoding, AHB response codes and a byte-lane helper.
package cache_cfg_pkg;

    localparam int OFF_CTRL  = 'h00;
    localparam int OFF_STAT  = 'h04;
    localparam int OFF_IRQEN = 'h08;
    localparam int OFF_HIT   = 'h0C;
    localparam int OFF_MISS  = 'h10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_HPDIS = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FDONE = 1;
    localparam int STAT_ERR   = 2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian AHB byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] l;
        case (size)
            3'd0:    l = 4'b0001 << a;
            3'd1:    l = a[1] ? 4'b1100 : 4'b0011;
            default: l = 4'b1111;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/cache_cfg_sat_cnt.sv
// Saturating event counter used for the cache hit/miss performance registers.
// A clear in the same cycle as an increment leaves the counter at zero.
module cache_cfg_sat_cnt
    import cache_cfg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_q = cnt_q;

endmodule

// File: rtl/cache_ahb_cfg_regs.sv
// AHB-Lite slave for cache control/status: CTRL, STAT (sticky W1C), IRQEN and,
// when CACHE_CFG_PERF_CNT_EN is defined, HIT_CNT/MISS_CNT performance counters.
module cache_ahb_cfg_regs
    import cache_cfg_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int RD_WAIT = 0,
    parameter int CNT_W   = 32
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic        i_hwrite,
    input  logic        i_hready,
    input  logic [31:0] i_haddr,
    input  logic [2:0]  i_hsize,
    input  logic [1:0]  i_htrans,
    input  logic [31:0] i_hwdata,
    output logic        o_hready,
    output logic        o_hresp,
    output logic [31:0] o_hrdata,
    input  logic [3:0]  i_hprot_mem,
    output logic        o_bypass,
    output logic        o_cache_dis,
    output logic        o_flush_req,
    input  logic        i_flush_done,
    input  logic        i_hit,
    input  logic        i_miss,
    output logic        o_irq
);

    localparam logic [1:0] RD_WAIT_L = 2'(RD_WAIT);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        wait_q, wait_d;
    logic              en_q, en_d, hpdis_q, hpdis_d, busy_q, busy_d;
    logic              fdone_q, fdone_d, errs_q, errs_d;
    logic [1:0]        irqen_q, irqen_d;

    logic              hready_c, resp_c, accept, req_err;
    logic              wr_en, rd_done, err_cycle;
    logic [REG_AW-1:0] woff;
    logic [3:0]        wlanes;
    logic [31:0]       rdata_c;

    function automatic logic is_mapped(input logic [REG_AW-1:0] off);
        logic [REG_AW-1:0] w;
        logic              m;
        w = {off[REG_AW-1:2], 2'b00};
        m = (w == REG_AW'(OFF_CTRL)) || (w == REG_AW'(OFF_STAT)) || (w == REG_AW'(OFF_IRQEN));
`ifdef CACHE_CFG_PERF_CNT_EN
        m = m || (w == REG_AW'(OFF_HIT)) || (w == REG_AW'(OFF_MISS));
`endif
        return m;
    endfunction

    assign hready_c = !((state_q == ST_ERR1) || ((state_q == ST_RD) && (wait_q != RD_WAIT_L)));
    assign accept   = i_hsel && i_htrans[1] && i_hready && hready_c;
    assign req_err  = (i_hsize > 3'd2)
                   || ((i_hsize == 3'd1) && i_haddr[0])
                   || ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00))
                   || !is_mapped(i_haddr[REG_AW-1:0]);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wait_d    = wait_q;
        resp_c    = HRESP_OKAY;
        wr_en     = 1'b0;
        rd_done   = 1'b0;
        err_cycle = 1'b0;
        case (state_q)
            ST_WR:   wr_en = 1'b1;
            ST_RD: begin
                if (wait_q != RD_WAIT_L) begin
                    wait_d = wait_q + 2'd1;
                end else begin
                    rd_done = 1'b1;
                end
            end
            ST_ERR1: begin
                resp_c    = HRESP_ERROR;
                err_cycle = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: resp_c = HRESP_ERROR;
            default: ;
        endcase
        // Any cycle that finishes the current data phase may also open the next one.
        if (hready_c) begin
            state_d = ST_IDLE;
            if (accept) begin
                addr_d  = i_haddr[REG_AW-1:0];
                size_d  = i_hsize;
                wait_d  = 2'd0;
                state_d = req_err ? ST_ERR1 : (i_hwrite ? ST_WR : ST_RD);
            end
        end
    end

    assign woff   = {addr_q[REG_AW-1:2], 2'b00};
    assign wlanes = byte_lanes(size_q, addr_q[1:0]);

    always_comb begin
        en_d    = en_q;
        hpdis_d = hpdis_q;
        busy_d  = busy_q;
        fdone_d = fdone_q;
        errs_d  = errs_q;
        irqen_d = irqen_q;
        if (wr_en && wlanes[0]) begin
            if (woff == REG_AW'(OFF_CTRL)) begin
                en_d    = i_hwdata[CTRL_EN];
                hpdis_d = i_hwdata[CTRL_HPDIS];
                if (i_hwdata[CTRL_FLUSH] && !busy_q) begin
                    busy_d = 1'b1;
                end
            end else if (woff == REG_AW'(OFF_STAT)) begin
                if (i_hwdata[STAT_FDONE]) fdone_d = 1'b0;
                if (i_hwdata[STAT_ERR])   errs_d  = 1'b0;
            end else if (woff == REG_AW'(OFF_IRQEN)) begin
                irqen_d = i_hwdata[2:1];
            end
        end
        // Hardware set events come last so they win over a same-cycle W1C.
        if (busy_q && i_flush_done) begin
            busy_d  = 1'b0;
            fdone_d = 1'b1;
        end
        if (err_cycle) begin
            errs_d = 1'b1;
        end
    end

`ifdef CACHE_CFG_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    cache_cfg_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .i_clk (i_hclk),
        .i_rst (i_hreset),
        .i_inc (i_hit),
        .i_clr (wr_en && (woff == REG_AW'(OFF_HIT))),
        .o_q   (hit_cnt)
    );

    cache_cfg_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
        .i_clk (i_hclk),
        .i_rst (i_hreset),
        .i_inc (i_miss),
        .i_clr (wr_en && (woff == REG_AW'(OFF_MISS))),
        .o_q   (miss_cnt)
    );
`endif

    always_comb begin
        rdata_c = 32'h0;
        if (rd_done) begin
            if (woff == REG_AW'(OFF_CTRL)) begin
                rdata_c[CTRL_EN]    = en_q;
                rdata_c[CTRL_HPDIS] = hpdis_q;
            end else if (woff == REG_AW'(OFF_STAT)) begin
                rdata_c[STAT_BUSY]  = busy_q;
                rdata_c[STAT_FDONE] = fdone_q;
                rdata_c[STAT_ERR]   = errs_q;
            end else if (woff == REG_AW'(OFF_IRQEN)) begin
                rdata_c[2:1] = irqen_q;
`ifdef CACHE_CFG_PERF_CNT_EN
            end else if (woff == REG_AW'(OFF_HIT)) begin
                rdata_c = 32'(hit_cnt);
            end else if (woff == REG_AW'(OFF_MISS)) begin
                rdata_c = 32'(miss_cnt);
`endif
            end
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wait_q  <= '0;
            en_q    <= 1'b0;
            hpdis_q <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            errs_q  <= 1'b0;
            irqen_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wait_q  <= wait_d;
            en_q    <= en_d;
            hpdis_q <= hpdis_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            errs_q  <= errs_d;
            irqen_q <= irqen_d;
        end
    end

    assign o_hready    = hready_c;
    assign o_hresp     = resp_c;
    assign o_hrdata    = rdata_c;
    assign o_bypass    = !en_q;
    assign o_cache_dis = hpdis_q & i_hprot_mem[0];
    assign o_flush_req = busy_q;
    assign o_irq       = |({errs_q, fdone_q} & irqen_q);

    logic unused_ok;
`ifdef CACHE_CFG_PERF_CNT_EN
    assign unused_ok = ^{i_haddr[31:REG_AW], i_htrans[0], i_hwdata[31:3], i_hprot_mem[3:1]};
`else
    assign unused_ok = ^{i_haddr[31:REG_AW], i_htrans[0], i_hwdata[31:3], i_hprot_mem[3:1],
                         i_hit, i_miss};
`endif

endmodule

// File: tb/tb_cache_ahb_cfg_regs.sv
// Scoreboard bench for cache_ahb_cfg_regs: directed register scenarios plus random
// AHB traffic, flush handshakes and hit/miss pulses against a behavioural model.
module tb_cache_ahb_cfg_regs;

    localparam int REG_AW_P  = 5;
    localparam int RD_WAIT_P = 2;
    localparam int CNT_W_P   = 3;
    localparam int CMAX      = (1 << CNT_W_P) - 1;
`ifdef CACHE_CFG_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst;
    logic        hsel, hwrite, hready, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic        bypass, cache_dis, flush_req, flush_done, hit, miss, irq;

    cache_ahb_cfg_regs #(.REG_AW(REG_AW_P), .RD_WAIT(RD_WAIT_P), .CNT_W(CNT_W_P)) dut (
        .i_hclk       (clk),
        .i_hreset     (rst),
        .i_hsel       (hsel),
        .i_hwrite     (hwrite),
        .i_hready     (hready),
        .i_haddr      (haddr),
        .i_hsize      (hsize),
        .i_htrans     (htrans),
        .i_hwdata     (hwdata),
        .o_hready     (hready),
        .o_hresp      (hresp),
        .o_hrdata     (hrdata),
        .i_hprot_mem  (hprot),
        .o_bypass     (bypass),
        .o_cache_dis  (cache_dis),
        .o_flush_req  (flush_req),
        .i_flush_done (flush_done),
        .i_hit        (hit),
        .i_miss       (miss),
        .o_irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural register model
    bit       m_en, m_hpdis, m_busy, m_fdone, m_err;
    bit [1:0] m_irqen;
    int       m_hit, m_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_en = 0; m_hpdis = 0; m_busy = 0; m_fdone = 0; m_err = 0;
        m_irqen = 0; m_hit = 0; m_miss = 0;
    endtask

    function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] s);
        int word;
        word = int'(a[4:2]);
        if (s > 3'd2) return 1'b1;
        if (s == 3'd1 && a[0]) return 1'b1;
        if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        if (word <= 2) return 1'b0;
        if ((word == 3 || word == 4) && PERF) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mdl_read(input int word);
        case (word)
            0:       return {30'b0, m_hpdis, m_en};
            1:       return {29'b0, m_err, m_fdone, m_busy};
            2:       return {29'b0, m_irqen, 1'b0};
            3:       return 32'(m_hit);
            4:       return 32'(m_miss);
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        bit lane0;
        int word;
        word  = int'(a[4:2]);
        lane0 = (s == 3'd0 && a[1:0] == 2'b00) || (s == 3'd1 && !a[1]) || (s == 3'd2);
        case (word)
            0: if (lane0) begin
                m_en = wd[0]; m_hpdis = wd[1];
                if (wd[2] && !m_busy) m_busy = 1;
            end
            1: if (lane0) begin
                if (wd[1]) m_fdone = 0;
                if (wd[2]) m_err = 0;
            end
            2: if (lane0) m_irqen = wd[2:1];
            3: m_hit = 0;
            4: m_miss = 0;
            default: ;
        endcase
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        exp_t e;
        bit   er;
        int   n;
        er      = mdl_err(a, s);
        e.addr  = a;
        e.err   = er;
        e.waits = er ? 1 : (wr ? 0 : RD_WAIT_P);
        e.rdata = (er || wr) ? 32'h0 : mdl_read(int'(a[4:2]));
        sbq.push_back(e);
        if (er) m_err = 1;
        else if (wr) mdl_write(a, s, wd);
        hsel = 1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = s;
        @(posedge clk); #1;
        hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (hready) break;
            n++;
            if (n > 16) begin
                n_checks++; n_errors++;
                $display("FAIL timeout addr=0x%0h", a);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_done();
        flush_done = 1;
        @(posedge clk); #1;
        flush_done = 0;
        if (m_busy) begin m_busy = 0; m_fdone = 1; end
    endtask

    task automatic pulse_hit(input bit is_miss);
        if (is_miss) miss = 1; else hit = 1;
        @(posedge clk); #1;
        hit = 0; miss = 0;
        if (PERF) begin
            if (is_miss) begin if (m_miss < CMAX) m_miss++; end
            else begin if (m_hit < CMAX) m_hit++; end
        end
    endtask

    task automatic chk_outs(input string tag);
        #1;
        chk({tag, ".bypass"},    32'(bypass),    32'(!m_en));
        chk({tag, ".cache_dis"}, 32'(cache_dis), 32'(m_hpdis & hprot[0]));
        chk({tag, ".flush_req"}, 32'(flush_req), 32'(m_busy));
        chk({tag, ".irq"},       32'(irq),       32'((m_fdone & m_irqen[0]) | (m_err & m_irqen[1])));
    endtask

    // Monitor: follows each accepted transfer through its data phase and scores it
    bit   mon_act = 0;
    int   mon_waits = 0;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 0;
        end else begin
            if (mon_act) begin
                if (!hready) begin
                    mon_waits++;
                    if (sbq.size() > 0) chk("wait_hresp", 32'(hresp), 32'(sbq[0].err));
                end else begin
                    if (sbq.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_response hresp=%0b hrdata=0x%0h", hresp, hrdata);
                    end else begin
                        me = sbq.pop_front();
                        chk($sformatf("hresp@%0h", me.addr),  32'(hresp), 32'(me.err));
                        chk($sformatf("hrdata@%0h", me.addr), hrdata, me.rdata);
                        chk($sformatf("waits@%0h", me.addr),  32'(mon_waits), 32'(me.waits));
                    end
                    mon_act = 0;
                end
            end else begin
                chk("idle_hready", 32'(hready), 32'h1);
                chk("idle_hresp",  32'(hresp),  32'h0);
                chk("idle_hrdata", hrdata,      32'h0);
            end
            if (hsel && htrans[1] && hready) begin
                mon_act   = 1;
                mon_waits = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        int          op;
        rst = 1; hsel = 0; hwrite = 0; htrans = 0; hsize = 0; haddr = 0; hwdata = 0;
        hprot = 4'h1; flush_done = 0; hit = 0; miss = 0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hready", 32'(hready), 32'h1);
        chk("rst.hresp",  32'(hresp),  32'h0);
        chk("rst.hrdata", hrdata,      32'h0);
        chk_outs("rst");
        rst = 0;
        @(posedge clk); #1;

        // Control enable and byte-lane write
        xfer(1, 32'h0, 3'd2, 32'h1);
        chk_outs("en");
        xfer(0, 32'h0, 3'd2, 32'h0);
        xfer(1, 32'h0, 3'd0, 32'h2);
        chk_outs("hpdis");
        xfer(0, 32'h0, 3'd2, 32'h0);
        xfer(1, 32'h1, 3'd0, 32'h0000_0500);
        xfer(0, 32'h0, 3'd2, 32'h0);

        // Unmapped, misaligned and oversize errors; sticky W1C
        xfer(0, 32'h14, 3'd2, 32'h0);
        xfer(0, 32'h4, 3'd2, 32'h0);
        xfer(1, 32'h4, 3'd2, 32'h4);
        xfer(0, 32'h4, 3'd2, 32'h0);
        xfer(1, 32'h1, 3'd1, 32'hFFFF_FFFF);
        xfer(1, 32'h0, 3'd3, 32'hFFFF_FFFF);
        xfer(0, 32'h0, 3'd2, 32'h0);
        xfer(1, 32'h4, 3'd2, 32'h4);

        // Flush handshake and interrupt
        xfer(1, 32'h0, 3'd2, 32'h5);
        chk_outs("flush");
        xfer(0, 32'h4, 3'd2, 32'h0);
        xfer(1, 32'h0, 3'd2, 32'h5);
        chk_outs("flush2");
        pulse_done();
        chk_outs("done");
        pulse_done();
        xfer(0, 32'h4, 3'd2, 32'h0);
        xfer(1, 32'h8, 3'd2, 32'h2);
        chk_outs("irq");
        xfer(1, 32'h4, 3'd0, 32'h2);
        chk_outs("irq_clr");

        // Performance counters (ERROR when the feature is absent)
        repeat (5) pulse_hit(0);
        xfer(0, 32'hC, 3'd2, 32'h0);
        repeat (4) pulse_hit(0);
        pulse_hit(1);
        xfer(0, 32'hC, 3'd2, 32'h0);
        xfer(0, 32'h10, 3'd2, 32'h0);
        xfer(1, 32'hE, 3'd0, 32'h0);
        xfer(0, 32'hC, 3'd2, 32'h0);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            a  = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            case (op)
                0, 1, 2: xfer(1, a, s, $urandom);
                3, 4, 5: xfer(0, a, s, 32'h0);
                6:       pulse_done();
                7:       repeat ($urandom_range(1, 3)) pulse_hit(0);
                8:       pulse_hit(1);
                default: xfer(1, 32'h0, 3'd2, {29'b0, 1'b1, 2'($urandom)});
            endcase
            hprot = 4'($urandom);
            chk_outs("rand");
        end

        // Asynchronous reset while a flush is outstanding
        if (!m_busy) xfer(1, 32'h0, 3'd2, 32'h5);
        chk_outs("pre_rst");
        #2;
        rst = 1;
        #1;
        chk("arst.flush_req", 32'(flush_req), 32'h0);
        chk("arst.bypass",    32'(bypass),    32'h1);
        chk("arst.irq",       32'(irq),       32'h0);
        mdl_reset();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        xfer(0, 32'h4, 3'd2, 32'h0);
        xfer(0, 32'h0, 3'd2, 32'h0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
